vend_dispenser: RTL

Sequential back end of the vending machine: accepts one purchase request (product code, item count, inserted money) over a valid/ready handshake and checks price and per-product stock. It then emits one dispense pulse per item and one change pulse per money unit returned, and finishes with a one-cycle completion strobe. It pairs with the combinational `vendingmachine` price checker and consumes the same `code`/`count`/`money` encoding.

---
 rtl/vend_dispenser.sv | 114 +++++++++++
 1 files changed

// File: rtl/vend_dispenser.sv
// vend_dispenser: sequential vending back end (price/stock check, dispense and change pulses).
// Optional `VEND_RESTOCK_EN adds a restock input that reloads all stock counters from IDLE.
module vend_dispenser #(
  parameter logic [3:0] PRICE0 = 4'd1,
  parameter logic [3:0] PRICE1 = 4'd2,
  parameter logic [3:0] PRICE2 = 4'd3,
  parameter logic [3:0] PRICE3 = 4'd4,
  parameter logic [2:0] STOCK_INIT = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef VEND_RESTOCK_EN
  input  logic       restock,
`endif
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] code,
  input  logic [2:0] count,
  input  logic [3:0] money,
  output logic       vend_pulse,
  output logic [1:0] vend_code,
  output logic       change_pulse,
  output logic       done,
  output logic       accepted,
  output logic [3:0] remaining
);
  typedef enum logic [2:0] {IDLE, CHECK, VEND, CHANGE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] code_q;
  logic [2:0] count_q;
  logic [3:0] money_q, left, left_n, chg_q, chg_n, chg_c, price;
  logic [2:0] stock [4];
  logic [6:0] total;
  logic ok_q, ok_n, ok_c, restock_i;
`ifdef VEND_RESTOCK_EN
  assign restock_i = restock;
`else
  assign restock_i = 1'b0;
`endif
  always_comb begin
    price = code_q == 2'd0 ? PRICE0 : code_q == 2'd1 ? PRICE1 : code_q == 2'd2 ? PRICE2 : PRICE3;
    total = {3'b0, price} * {4'b0, count_q};
    ok_c = (count_q != 3'd0) && (total <= {3'b0, money_q}) && (stock[code_q] >= count_q);
    chg_c = ok_c ? money_q - total[3:0] : money_q;
  end
  // left counts the pulses still owed in the current VEND or CHANGE phase
  always_comb begin
    state_n = state;
    left_n = left;
    ok_n = ok_q;
    chg_n = chg_q;
    case (state)
      IDLE: state_n = req_valid ? CHECK : IDLE;
      CHECK: begin
        ok_n = ok_c;
        chg_n = chg_c;
        state_n = ok_c ? VEND : (chg_c != 4'd0 ? CHANGE : DONE);
        left_n = ok_c ? {1'b0, count_q} : chg_c;
      end
      VEND: begin
        left_n = left == 4'd1 ? chg_q : left - 4'd1;
        state_n = left != 4'd1 ? VEND : (chg_q != 4'd0 ? CHANGE : DONE);
      end
      CHANGE: begin
        left_n = left - 4'd1;
        state_n = left == 4'd1 ? DONE : CHANGE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      left <= '0;
      ok_q <= 1'b0;
      chg_q <= '0;
      code_q <= '0;
      count_q <= '0;
      money_q <= '0;
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_INIT;
      req_ready <= 1'b1;
      vend_pulse <= 1'b0;
      vend_code <= '0;
      change_pulse <= 1'b0;
      done <= 1'b0;
      accepted <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_n;
      left <= left_n;
      ok_q <= ok_n;
      chg_q <= chg_n;
      if (state == IDLE && req_valid) begin
        code_q <= code;
        count_q <= count;
        money_q <= money;
      end
      if (state == IDLE && restock_i)
        for (int i = 0; i < 4; i++) stock[i] <= STOCK_INIT;
      else if (state == VEND)
        stock[code_q] <= stock[code_q] - 3'd1;
      // outputs are registered copies of the next-state decode
      req_ready <= state_n == IDLE;
      vend_pulse <= state_n == VEND;
      vend_code <= state_n == VEND ? code_q : 2'd0;
      change_pulse <= state_n == CHANGE;
      done <= state_n == DONE;
      if (state_n == DONE) begin
        accepted <= ok_n;
        remaining <= chg_n;
      end
    end
  end
endmodule
